mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder at the far end of the core's IORead/IOWrite interface. The control unit asserts these strobes when a load or store address has Alu_resultHigh == 22'h3FFFFF, i.e. the window 0xFFFFFC00–0xFFFFFFFF.
- The block decodes the low address bits, holds the output registers for LEDs and the seven-segment display, synchronises and debounces board inputs, and runs a millisecond timer.
- It returns read data into the core's MemorIOToReg mux.

Parameters:
- LED_WIDTH, 16, width of LED output register
- SW_WIDTH, 16, width of switch input
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced button level changes (10 ms at 100 MHz)
- TIMER_DIV, 100000, clock cycles per TIMER increment (1 ms at 100 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- IORead  in  1  load to the IO window this cycle
- IOWrite  in  1  store to the IO window this cycle
- io_addr  in  10  byte offset within the IO window (addr[9:0])
- io_wdata  in  32  store data
- io_rdata  out  32  load data
- switch_in  in  SW_WIDTH  raw board switches (asynchronous)
- button_in  in  1  raw push button (asynchronous, bouncy)
- led_out  out  LED_WIDTH  LED drive
- seg_data  out  32  eight hex nibbles for the display driver; digit 0 is bits [3:0]

Behaviour:
- Register map (word-aligned; io_addr[1:0] ignored):
  - 0x000 LED, RW.
  - 0x004 SWITCH, RO, synchronised value.
  - 0x008 BTN, RO: bit0 = debounced level, bit1 = press event (sticky), other bits 0.
  - 0x00C SEG, RW, 32 bits.
  - 0x010 TIMER, RO count; any write clears it.
  - Any other offset: reads return 0, writes are ignored.
- Reset (rst_n low, asynchronous):
  - led_out=0, seg_data=0, TIMER=0, prescaler=0.
  - Synchroniser flops=0, debounced level=0, debounce counter=0, press event=0.
  - Reset mid-debounce or mid-prescale discards all partial progress.
- Writes:
  - Take effect at the rising clk edge when IOWrite=1.
  - LED takes io_wdata[LED_WIDTH-1:0]; SEG takes io_wdata[31:0].
  - TIMER write zeroes both TIMER and the prescaler on that edge.
- Reads:
  - io_rdata is combinational from current register state while IORead=1, with zero added latency so the single-cycle core consumes it the same cycle.
  - io_rdata=0 when IORead=0.
- Read side effect: a BTN read with IORead=1 clears the press event at the closing clock edge. If a new press event occurs on that same edge, set wins and the event stays 1.
- IORead and IOWrite both high is illegal from the decoder. The write is performed and read data is still returned.
- Input synchronisation:
  - switch_in and button_in pass through 2-flop synchronisers.
  - SWITCH reads therefore lag the pins by 2 cycles.
- Debounce:
  - Counter resets to 0 whenever the synchronised button equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 the debounced level toggles and the counter clears.
  - A 0→1 transition of the debounced level sets the press event.
  - Release (1→0) sets nothing.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; on wrap to 0, TIMER increments.
  - TIMER wraps from 0xFFFFFFFF to 0 silently.
  - A write on the wrap edge wins, so TIMER=0.

Decomposition:
- Package mmio_map_pkg holds:
  - the offset constants (OFF_LED, OFF_SW, OFF_BTN, OFF_SEG, OFF_TIMER)
  - the BTN bit indices
  - the IO window high constant 22'h3FFFFF, shared with instruction_control
- Sub-module mmio_debounce (parameter CYCLES): 2-flop synchroniser, debounce counter, level output and 1-cycle rising-edge pulse output. It is instantiated once for the button.

Test Plan:
- Reset and LED write: rst_n low with pins active → all outputs 0. Release reset, then IOWrite io_addr=0x000 io_wdata=0xDEADBEEF → led_out=16'hBEEF the next cycle. IORead 0x000 returns 0x0000BEEF.
- SEG and unmapped access: IOWrite 0x00C 0x12345678 → seg_data=0x12345678. Write to 0x020 changes nothing. IORead 0x020 → 0. IORead=0 → io_rdata=0.
- Switch sync: switch_in=16'hA5A5 → IORead 0x004 reads 0 for 2 cycles, then 0x0000A5A5.
- Debounce and event (DEBOUNCE_CYCLES=4): toggle button_in every cycle for 10 cycles → BTN stays 0. Hold it high → BTN=0x3 after 2+4 cycles. A BTN read clears it to 0x1. A read coinciding with a new press keeps bit1=1.
- Timer (TIMER_DIV=3): 9 cycles after reset TIMER=3. IOWrite 0x010 → TIMER=0 and the prescaler restarts. Force TIMER to 0xFFFFFFFF → the next increment reads 0.
- Async reset mid-operation: assert rst_n low between clock edges during debounce count 2 → all state is 0 immediately without waiting for clk. The full debounce is required again after release.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Address map, register selector and BTN bit layout shared by the IO
// window responder and the core's instruction decoder.
package mmio_map_pkg;

  // Upper address bits that select the IO window (0xFFFFFC00-0xFFFFFFFF).
  localparam logic [21:0] IO_WINDOW_HIGH = 22'h3F_FFFF;

  // Byte offsets of the registers inside the window.
  localparam logic [9:0] OFF_LED   = 10'h000;
  localparam logic [9:0] OFF_SW    = 10'h004;
  localparam logic [9:0] OFF_BTN   = 10'h008;
  localparam logic [9:0] OFF_SEG   = 10'h00C;
  localparam logic [9:0] OFF_TIMER = 10'h010;

  // Bit positions inside the BTN register.
  localparam int BTN_LEVEL_BIT = 0;
  localparam int BTN_EVENT_BIT = 1;

  typedef enum logic [2:0] {
    REG_LED   = 3'd0,
    REG_SW    = 3'd1,
    REG_BTN   = 3'd2,
    REG_SEG   = 3'd3,
    REG_TIMER = 3'd4,
    REG_NONE  = 3'd5
  } reg_sel_e;

  // Map a byte offset to a register; the two byte-lane bits are ignored.
  function automatic reg_sel_e decode_reg(input logic [9:0] addr);
    reg_sel_e sel;
    case ({addr[9:2], 2'b00})
      OFF_LED:   sel = REG_LED;
      OFF_SW:    sel = REG_SW;
      OFF_BTN:   sel = REG_BTN;
      OFF_SEG:   sel = REG_SEG;
      OFF_TIMER: sel = REG_TIMER;
      default:   sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// IORead/IOWrite bus between the core (master) and the IO responder (slave).
interface mmio_responder_if;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output IORead,
    output IOWrite,
    output io_addr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  IORead,
    input  IOWrite,
    input  io_addr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/mmio_responder_debounce.sv
// Two-flop synchroniser followed by a stability counter for one bouncy input.
// rise_o is high during the single cycle whose closing edge turns level_o
// from 0 to 1, so a consumer flop can capture the press on the same edge.
module mmio_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int            CW      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          flip_s;

  // Count consecutive cycles the synchronised input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    flip_s  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = {CW{1'b0}};
      flip_s  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, debounced level and stability counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = flip_s & ~level_q;

endmodule

// File: rtl/mmio_responder.sv
// IO window responder: LED and seven-segment registers, synchronised
// switches, debounced button with sticky press event, millisecond timer.
// Read data is combinational so the single-cycle core sees it in-cycle.
module mmio_responder
  import mmio_map_pkg::*;
#(
  parameter int LED_WIDTH       = 16,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMER_DIV       = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_responder_if.slave      bus,
  input  logic [SW_WIDTH-1:0]  switch_in,
  input  logic                 button_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [31:0]          seg_data
);

  localparam int            PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  reg_sel_e             sel_s;
  logic                 wr_led_s;
  logic                 wr_seg_s;
  logic                 wr_timer_s;
  logic                 rd_btn_s;
  logic                 btn_level_s;
  logic                 btn_rise_s;
  logic [31:0]          rdata_s;

  logic [LED_WIDTH-1:0] led_q;
  logic [LED_WIDTH-1:0] led_d;
  logic [31:0]          seg_q;
  logic [31:0]          seg_d;
  logic [SW_WIDTH-1:0]  sw_sync1_q;
  logic [SW_WIDTH-1:0]  sw_sync2_q;
  logic [31:0]          timer_q;
  logic [31:0]          timer_d;
  logic [PW-1:0]        presc_q;
  logic [PW-1:0]        presc_d;
  logic                 press_q;
  logic                 press_d;

  assign sel_s      = decode_reg(bus.io_addr);
  assign wr_led_s   = bus.IOWrite & (sel_s == REG_LED);
  assign wr_seg_s   = bus.IOWrite & (sel_s == REG_SEG);
  assign wr_timer_s = bus.IOWrite & (sel_s == REG_TIMER);
  assign rd_btn_s   = bus.IORead  & (sel_s == REG_BTN);

  mmio_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (button_in),
    .level_o (btn_level_s),
    .rise_o  (btn_rise_s)
  );

  // Next state of the writable registers and the sticky press event.
  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (wr_led_s) begin
      led_d = bus.io_wdata[LED_WIDTH-1:0];
    end else begin
      led_d = led_q;
    end
    if (wr_seg_s) begin
      seg_d = bus.io_wdata;
    end else begin
      seg_d = seg_q;
    end
    // A BTN read clears the event, but a press landing on the same edge wins.
    press_d = (press_q & ~rd_btn_s) | btn_rise_s;
  end

  // Prescaler and timer; a TIMER write restarts both, even on a wrap edge.
  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    if (wr_timer_s) begin
      presc_d = {PW{1'b0}};
      timer_d = 32'h0000_0000;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = {PW{1'b0}};
      timer_d = timer_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Register state, switch synchroniser and timer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= {LED_WIDTH{1'b0}};
      seg_q      <= 32'h0000_0000;
      sw_sync1_q <= {SW_WIDTH{1'b0}};
      sw_sync2_q <= {SW_WIDTH{1'b0}};
      timer_q    <= 32'h0000_0000;
      presc_q    <= {PW{1'b0}};
      press_q    <= 1'b0;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      sw_sync1_q <= switch_in;
      sw_sync2_q <= sw_sync1_q;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      press_q    <= press_d;
    end
  end

  // Read mux from current register state; zero when no load is in flight.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.IORead) begin
      case (sel_s)
        REG_LED:   rdata_s = 32'(led_q);
        REG_SW:    rdata_s = 32'(sw_sync2_q);
        REG_BTN: begin
          rdata_s[BTN_LEVEL_BIT] = btn_level_s;
          rdata_s[BTN_EVENT_BIT] = press_q;
        end
        REG_SEG:   rdata_s = seg_q;
        REG_TIMER: rdata_s = timer_q;
        default:   rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.io_rdata = rdata_s;
  assign led_out      = led_q;
  assign seg_data     = seg_q;

endmodule
